// File: rtl/regfile_dump_reader_pkg.sv
// Shared types and constants for the register-file dump reader.
// Optional feature macro: REGDUMP_SKIP_ZERO_EN (skip zero-valued registers).
package regfile_dump_reader_pkg;

    localparam int RD_NUM_REGS = 32;
    localparam int RD_ADDR_W   = 5;
    localparam int RD_DATA_W   = 32;

    typedef logic [RD_DATA_W-1:0] word_t;
    typedef logic [RD_ADDR_W-1:0] regbits_t;
    typedef logic [RD_ADDR_W:0]   regcount_t;

    localparam regbits_t REGDUMP_LAST = regbits_t'(RD_NUM_REGS - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SEND,
        DONE
    } regdump_state_t;

endpackage

// File: rtl/regfile_dump_reader.sv
// Sweeps the register file through one read port and streams each word out over valid/ready.
// Optional feature macro: REGDUMP_SKIP_ZERO_EN (zero-valued registers are not emitted).
module regfile_dump_reader
    import regfile_dump_reader_pkg::*;
#(
    parameter int NUM_REGS = RD_NUM_REGS,
    parameter int ADDR_W   = RD_ADDR_W,
    parameter int DATA_W   = RD_DATA_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              dump_req,
    output logic [ADDR_W-1:0] rsel,
    input  logic [DATA_W-1:0] rdat,
    output logic              busy,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_addr,
    output logic [DATA_W-1:0] dump_data,
    output logic [ADDR_W:0]   dump_count,
    output logic              dump_done
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NUM_REGS - 1);

    regdump_state_t    state_q, state_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [ADDR_W:0]   count_q, count_d;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            index_q <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            count_q <= count_d;
        end
    end

    // dump_count is cleared only when a new sweep starts so the last total stays visible.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        addr_d  = addr_q;
        data_d  = data_q;
        count_d = count_q;
        case (state_q)
            IDLE: begin
                if (dump_req) begin
                    state_d = READ;
                    index_d = '0;
                    count_d = '0;
                end
            end
            READ: begin
`ifdef REGDUMP_SKIP_ZERO_EN
                if (rdat == '0) begin
                    if (index_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        index_d = index_q + 1'b1;
                    end
                end else begin
                    addr_d  = index_q;
                    data_d  = rdat;
                    state_d = SEND;
                end
`else
                addr_d  = index_q;
                data_d  = rdat;
                state_d = SEND;
`endif
            end
            SEND: begin
                if (dump_ready) begin
                    count_d = count_q + 1'b1;
                    if (index_q == LAST_IDX) begin
                        state_d = DONE;
                    end else begin
                        index_d = index_q + 1'b1;
                        state_d = READ;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // The read port is only driven while actually reading so the halt mux sees 0 otherwise.
    assign rsel       = (state_q == READ) ? index_q : '0;
    assign busy       = (state_q != IDLE);
    assign dump_valid = (state_q == SEND);
    assign dump_done  = (state_q == DONE);
    assign dump_addr  = addr_q;
    assign dump_data  = data_q;
    assign dump_count = count_q;

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed self-checking bench for regfile_dump_reader with a behavioural register file.
// Honours REGDUMP_SKIP_ZERO_EN when building expected word lists.
module tb_regfile_dump_reader;
    import regfile_dump_reader_pkg::*;

    localparam int NR = RD_NUM_REGS;

    logic      CLK = 1'b0;
    logic      RST = 1'b1;
    logic      dump_req = 1'b0;
    logic      dump_ready = 1'b0;
    regbits_t  rsel;
    word_t     rdat;
    logic      busy;
    logic      dump_valid;
    regbits_t  dump_addr;
    word_t     dump_data;
    regcount_t dump_count;
    logic      dump_done;

    word_t regs [NR];
    int    compareCount = 0;
    int    mismatchCount = 0;
    int    expAddr[$];
    int    expEdge[$];
    int    expDoneEdge;

    always #5 CLK = ~CLK;

    assign rdat = regs[rsel];

    regfile_dump_reader #(
        .NUM_REGS(RD_NUM_REGS),
        .ADDR_W  (RD_ADDR_W),
        .DATA_W  (RD_DATA_W)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .dump_req  (dump_req),
        .rsel      (rsel),
        .rdat      (rdat),
        .busy      (busy),
        .dump_valid(dump_valid),
        .dump_ready(dump_ready),
        .dump_addr (dump_addr),
        .dump_data (dump_data),
        .dump_count(dump_count),
        .dump_done (dump_done)
    );

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compareCount++;
        if (obs !== exp) begin
            mismatchCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Edge numbering: edge 0 is where req is driven, edge 1 samples it; READ costs one
    // edge and SEND (ready high) one more, so a word handshakes two edges after its READ starts.
    function automatic void buildExp();
        int  t;
        bit  emit;
        t = 1;
        expAddr.delete();
        expEdge.delete();
        for (int i = 0; i < NR; i++) begin
            emit = 1'b1;
`ifdef REGDUMP_SKIP_ZERO_EN
            emit = (regs[i] != '0);
`endif
            if (emit) begin
                expAddr.push_back(i);
                expEdge.push_back(t + 2);
                t += 2;
            end else begin
                t += 1;
            end
        end
        expDoneEdge = t;
    endfunction

    // Runs one sweep, starting #1 after a rising edge; stallReg/reqAgainReg < 0 disable those events.
    task automatic applyStimulus(input int stallReg, input int reqAgainReg, input bit checkTiming);
        int       e;
        int       words;
        int       doneCnt;
        int       doneEdge;
        bit       stalled;
        bit       hs;
        regbits_t a;
        word_t    d;
        e = 0;
        words = 0;
        doneCnt = 0;
        doneEdge = -1;
        stalled = 1'b0;
        buildExp();
        dump_ready = 1'b1;
        dump_req = 1'b1;
        while (e < 400 && !(doneEdge >= 0 && e > doneEdge)) begin
            @(negedge CLK);
            if (stallReg >= 0 && !stalled && dump_valid && dump_addr == regbits_t'(stallReg)) begin
                stalled = 1'b1;
                dump_ready = 1'b0;
                a = dump_addr;
                d = dump_data;
                for (int k = 0; k < 5; k++) begin
                    @(posedge CLK);
                    e++;
                    #1;
                    checkOutput("stallValid", dump_valid, 1);
                    checkOutput("stallAddr", dump_addr, a);
                    checkOutput("stallData", dump_data, d);
                    checkOutput("stallCount", dump_count, words);
                end
                dump_ready = 1'b1;
                @(negedge CLK);
            end
            hs = dump_valid && dump_ready;
            if (reqAgainReg >= 0 && dump_valid && dump_addr == regbits_t'(reqAgainReg))
                dump_req = 1'b1;
            @(posedge CLK);
            e++;
            #1;
            dump_req = 1'b0;
            if (hs) begin
                if (words < expAddr.size()) begin
                    checkOutput("wordAddr", dump_addr, expAddr[words]);
                    checkOutput("wordData", dump_data, regs[expAddr[words]]);
                    checkOutput("wordCount", dump_count, words + 1);
                    if (checkTiming)
                        checkOutput("wordEdge", e, expEdge[words]);
                end else begin
                    checkOutput("wordLimit", words + 1, expAddr.size());
                end
                words++;
            end
            if (dump_done) begin
                doneCnt++;
                if (doneEdge < 0)
                    doneEdge = e;
            end
        end
        checkOutput("totalWords", words, expAddr.size());
        checkOutput("donePulses", doneCnt, 1);
        checkOutput("finalCount", dump_count, expAddr.size());
        if (checkTiming)
            checkOutput("doneEdge", doneEdge, expDoneEdge);
        checkOutput("endBusy", busy, 0);
    endtask

    initial begin
        bit found;
        for (int i = 0; i < NR; i++) regs[i] = '0;

        #1;
        checkOutput("resetRsel", rsel, 0);
        checkOutput("resetBusy", busy, 0);
        checkOutput("resetValid", dump_valid, 0);
        checkOutput("resetDone", dump_done, 0);
        checkOutput("resetAddr", dump_addr, 0);
        checkOutput("resetData", dump_data, 0);
        checkOutput("resetCount", dump_count, 0);
        @(negedge CLK);
        RST = 1'b0;
        @(posedge CLK);
        #1;

        $display("[TB] idle quiescence");
        for (int c = 0; c < 100; c++) begin
            @(posedge CLK);
            #1;
            checkOutput("idleBusy", busy, 0);
            checkOutput("idleRsel", rsel, 0);
            checkOutput("idleValid", dump_valid, 0);
            checkOutput("idleDone", dump_done, 0);
        end

        $display("[TB] full sweep, ready high");
        for (int i = 0; i < NR; i++) regs[i] = 32'hA000_0000 + word_t'(i);
        applyStimulus(-1, -1, 1'b1);

        $display("[TB] backpressure on reg 3");
        applyStimulus(3, -1, 1'b0);

        $display("[TB] request while busy at reg 10");
        applyStimulus(-1, 10, 1'b1);

        $display("[TB] async reset during SEND of reg 7");
        dump_ready = 1'b1;
        dump_req = 1'b1;
        @(posedge CLK);
        #1;
        dump_req = 1'b0;
        found = 1'b0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge CLK);
            if (dump_valid && dump_addr == regbits_t'(7)) found = 1'b1;
        end
        checkOutput("reachReg7", found, 1);
        RST = 1'b1;
        #1;
        checkOutput("rstRsel", rsel, 0);
        checkOutput("rstBusy", busy, 0);
        checkOutput("rstValid", dump_valid, 0);
        checkOutput("rstDone", dump_done, 0);
        checkOutput("rstAddr", dump_addr, 0);
        checkOutput("rstData", dump_data, 0);
        checkOutput("rstCount", dump_count, 0);
        #2;
        RST = 1'b0;
        @(posedge CLK);
        #1;
        checkOutput("postRstBusy", busy, 0);
        applyStimulus(-1, -1, 1'b1);

        $display("[TB] sparse file, regs 2/17/31 nonzero");
        for (int i = 0; i < NR; i++) regs[i] = '0;
        regs[2]  = 32'h1234_0002;
        regs[17] = 32'h5678_0011;
        regs[31] = 32'h9ABC_001F;
        applyStimulus(-1, -1, 1'b1);

        $display("[TB] all-zero file");
        for (int i = 0; i < NR; i++) regs[i] = '0;
        applyStimulus(-1, -1, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
        $finish;
    end

endmodule
